// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//
// Purpose: one sram-like request/response channel. The arbiter uses three of
// them: one per upstream master (instruction fetch and data) and one toward
// the slave port of the AXI bridge.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width
//
// Signals:
//   req      request valid, driven by the requester
//   wr       1 = write, 0 = read
//   size     access size, bytes = 1 << size
//   wstrb    byte enables for writes
//   addr     byte address
//   wdata    write data
//   addr_ok  request accepted, driven by the responder
//   data_ok  response returned, driven by the responder
//   rdata    read data, valid with data_ok
//
// Modports:
//   master  the requesting side (drives req and the request fields)
//   slave   the responding side (drives addr_ok, data_ok, rdata)

interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output wr,
    output size,
    output wstrb,
    output addr,
    output wdata,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  wr,
    input  size,
    input  wstrb,
    input  addr,
    input  wdata,
    output addr_ok,
    output data_ok,
    output rdata
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Purpose: shares one sram-like slave port (toward the AXI bridge) between
// the instruction-fetch master and the data master. Only one transaction is
// outstanding at a time. A registered grant FSM (IDLE -> ADDR -> DATA)
// latches the owner. It forwards that owner's request fields to the slave
// and routes addr_ok, data_ok and rdata back to the owner only.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   reset     synchronous, active-high reset
//   inst_bus  instruction master channel (arbiter is the responder)
//   data_bus  data master channel (arbiter is the responder)
//   sram_bus  channel to the shared slave (arbiter is the requester)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration with a pointer
//                                    that flips to the other master after
//                                    every grant
//                       undefined -> fixed priority, data over inst. There
//                                    is no pointer register.

module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  sram_port_arbiter_if.slave  inst_bus,
  sram_port_arbiter_if.slave  data_bus,
  sram_port_arbiter_if.master sram_bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;

  // 0 = instruction master owns the port, 1 = data master owns it.
  logic owner;

  // Set when reset interrupts a transaction. The slave may still deliver
  // that transaction's data_ok. This flag lets exactly one such late response
  // be absorbed silently. It clears on that response, or once a new
  // transaction reaches DATA.
  logic stale_resp;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = inst preferred on a tie, 1 = data preferred.
  logic prefer_data;
`endif

  logic any_req;
  logic grant_data;
  logic owner_req;

  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_wdata;
  logic [DATA_W-1:0] ret_rdata;

  // Arbitration decision, evaluated every cycle. It is only acted on in
  // IDLE, or in DATA on the cycle the slave returns data_ok. A lone
  // requester always wins. The tie-break is the only part the configuration
  // changes.
  always_comb begin
    any_req = inst_bus.req | data_bus.req;
`ifdef ARB_ROUND_ROBIN_EN
    grant_data = data_bus.req & (~inst_bus.req | prefer_data);
`else
    grant_data = data_bus.req;
`endif
    owner_req = owner ? data_bus.req : inst_bus.req;
  end

  // Grant FSM. The owner is latched whenever a grant is made. ADDR leaves
  // either on the slave handshake or when the owner withdraws its request.
  // DATA waits for data_ok and then re-arbitrates in the same cycle, so a
  // pending master is presented to the slave on the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      if (state != IDLE) begin
        stale_resp <= 1'b1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      prefer_data <= 1'b0;
`endif
    end else begin
      if (sram_bus.data_ok && (state != DATA)) begin
        stale_resp <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant_data;
            state <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_data <= ~grant_data;
`endif
          end
        end
        ADDR: begin
          if (!owner_req) begin
            state <= IDLE;
          end else if (sram_bus.addr_ok) begin
            state      <= DATA;
            stale_resp <= 1'b0;
          end
        end
        DATA: begin
          if (sram_bus.data_ok) begin
            if (any_req) begin
              owner <= grant_data;
              state <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
              prefer_data <= ~grant_data;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request-side mux. The slave sees the owner's fields only while in ADDR.
  // In every other state all outputs are held at zero, so nothing leaks
  // to the slave between transactions. req follows the owner's req
  // combinationally, which makes an abort visible in the same cycle.
  always_comb begin
    fwd_addr  = owner ? data_bus.addr  : inst_bus.addr;
    fwd_wdata = owner ? data_bus.wdata : inst_bus.wdata;

    sram_bus.req   = 1'b0;
    sram_bus.wr    = 1'b0;
    sram_bus.size  = 2'b00;
    sram_bus.wstrb = 4'h0;
    sram_bus.addr  = '0;
    sram_bus.wdata = '0;

    if (state == ADDR) begin
      sram_bus.req   = owner_req;
      sram_bus.wr    = owner ? data_bus.wr    : inst_bus.wr;
      sram_bus.size  = owner ? data_bus.size  : inst_bus.size;
      sram_bus.wstrb = owner ? data_bus.wstrb : inst_bus.wstrb;
      sram_bus.addr  = fwd_addr;
      sram_bus.wdata = fwd_wdata;
    end
  end

  // Response routing back to the instruction master. The non-owner always
  // sees zero acks and zero rdata. addr_ok is passed only in ADDR, and
  // data_ok/rdata only in DATA. A data_ok in any other state is dropped.
  always_comb begin
    ret_rdata = sram_bus.rdata;

    inst_bus.addr_ok = 1'b0;
    inst_bus.data_ok = 1'b0;
    inst_bus.rdata   = '0;

    if (!owner) begin
      if (state == ADDR) begin
        inst_bus.addr_ok = sram_bus.addr_ok;
      end
      if (state == DATA) begin
        inst_bus.data_ok = sram_bus.data_ok;
        inst_bus.rdata   = ret_rdata;
      end
    end
  end

  // Response routing back to the data master. This mirrors the
  // instruction-side routing above.
  always_comb begin
    data_bus.addr_ok = 1'b0;
    data_bus.data_ok = 1'b0;
    data_bus.rdata   = '0;

    if (owner) begin
      if (state == ADDR) begin
        data_bus.addr_ok = sram_bus.addr_ok;
      end
      if (state == DATA) begin
        data_bus.data_ok = sram_bus.data_ok;
        data_bus.rdata   = sram_bus.rdata;
      end
    end
  end

  // A data_ok with no transaction in DATA is a slave protocol error. The
  // one exception is the late response of a transaction that reset cut off.
  arb_spurious_data_ok: assert property (
    @(posedge clk) disable iff (reset)
      !(sram_bus.data_ok && (state != DATA) && !stale_resp)
  );

  // At most one master is ever acknowledged in a given cycle.
  arb_single_addr_ok: assert property (
    @(posedge clk) disable iff (reset)
      !(inst_bus.addr_ok && data_bus.addr_ok)
  );

  arb_single_data_ok: assert property (
    @(posedge clk) disable iff (reset)
      !(inst_bus.data_ok && data_bus.data_ok)
  );

  // The slave is never asked for a new transaction while one is in flight.
  arb_no_req_in_data: assert property (
    @(posedge clk) disable iff (reset)
      (state == DATA) |-> !sram_bus.req
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//
// Purpose: directed, self-checking bench for sram_port_arbiter. The bench
// plays both upstream masters and the slave. Inputs change on the falling
// edge, and outputs are checked 1 time unit later. Every expected value is
// written out by hand for the step it belongs to.
//
// Ports: none (top-level bench). Build with ARB_ROUND_ROBIN_EN defined to
// check the round-robin tie order instead of fixed priority.

module tb_sram_port_arbiter;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sram_if ();

  sram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .sram_bus (sram_if)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expected value. On a mismatch,
  // counts the failure and reports the tag and both values.
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Both masters and the slave go quiet.
  task automatic drive_idle();
    inst_if.req = 1'b0;  inst_if.wr = 1'b0;  inst_if.size = 2'd0;
    inst_if.wstrb = 4'h0; inst_if.addr = '0; inst_if.wdata = '0;
    data_if.req = 1'b0;  data_if.wr = 1'b0;  data_if.size = 2'd0;
    data_if.wstrb = 4'h0; data_if.addr = '0; data_if.wdata = '0;
    sram_if.addr_ok = 1'b0; sram_if.data_ok = 1'b0; sram_if.rdata = '0;
  endtask

  logic        exp_data;
  logic [31:0] exp_addr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);

    // Reset state.
    @(negedge clk); #1;
    check_output("rst_req",          sram_if.req,     0);
    check_output("rst_addr",         sram_if.addr,    0);
    check_output("rst_inst_addr_ok", inst_if.addr_ok, 0);
    check_output("rst_data_data_ok", data_if.data_ok, 0);
    check_output("rst_inst_rdata",   inst_if.rdata,   0);
    reset = 1'b0;

    // Single instruction read.
    $display("[TB] single inst read");
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0000; inst_if.size = 2'd2;
    #1 check_output("t1_c0_req", sram_if.req, 0);
    @(negedge clk); #1;
    check_output("t1_c1_req",     sram_if.req,     1);
    check_output("t1_c1_addr",    sram_if.addr,    32'hBFC0_0000);
    check_output("t1_c1_addr_ok", inst_if.addr_ok, 0);
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1;
    check_output("t1_c2_inst_addr_ok", inst_if.addr_ok, 1);
    check_output("t1_c2_data_addr_ok", data_if.addr_ok, 0);
    @(negedge clk);
    inst_if.req = 1'b0; sram_if.addr_ok = 1'b0;
    #1;
    check_output("t1_c3_req",     sram_if.req,     0);
    check_output("t1_c3_addr_ok", inst_if.addr_ok, 0);
    check_output("t1_c3_data_ok", inst_if.data_ok, 0);
    @(negedge clk);
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h3C08_0001;
    #1;
    check_output("t1_c4_inst_data_ok", inst_if.data_ok, 1);
    check_output("t1_c4_inst_rdata",   inst_if.rdata,   32'h3C08_0001);
    check_output("t1_c4_data_data_ok", data_if.data_ok, 0);
    check_output("t1_c4_data_rdata",   data_if.rdata,   0);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;
    #1;
    check_output("t1_c5_data_ok", inst_if.data_ok, 0);
    check_output("t1_c5_req",     sram_if.req,     0);
    check_output("t1_c5_addr",    sram_if.addr,    0);

    // Tie with data writing. Data wins under fixed priority. Under
    // round-robin the pointer prefers data after the inst grant above.
    $display("[TB] tie, data write first");
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h0040_0000; inst_if.wr = 1'b0;
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.addr = 32'h8000_1000;
    data_if.wstrb = 4'hF; data_if.wdata = 32'hDEAD_BEEF; data_if.size = 2'd2;
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1;
    check_output("t2_req",          sram_if.req,     1);
    check_output("t2_wr",           sram_if.wr,      1);
    check_output("t2_addr",         sram_if.addr,    32'h8000_1000);
    check_output("t2_wstrb",        sram_if.wstrb,   4'hF);
    check_output("t2_wdata",        sram_if.wdata,   32'hDEAD_BEEF);
    check_output("t2_data_addr_ok", data_if.addr_ok, 1);
    check_output("t2_inst_addr_ok", inst_if.addr_ok, 0);
    @(negedge clk);
    data_if.req = 1'b0; sram_if.addr_ok = 1'b0; sram_if.data_ok = 1'b1;
    #1;
    check_output("t2_data_data_ok", data_if.data_ok, 1);
    check_output("t2_inst_data_ok", inst_if.data_ok, 0);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.addr_ok = 1'b1;
    #1;
    check_output("t2_inst_req",     sram_if.req,     1);
    check_output("t2_inst_addr",    sram_if.addr,    32'h0040_0000);
    check_output("t2_inst_wr",      sram_if.wr,      0);
    check_output("t2_inst_addr_ok", inst_if.addr_ok, 1);
    @(negedge clk);
    inst_if.req = 1'b0; sram_if.addr_ok = 1'b0;
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h1234_5678;
    #1;
    check_output("t2_inst_rdata", inst_if.rdata, 32'h1234_5678);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;

    // Both masters hold req for four transactions, starting from reset so
    // that the round-robin pointer prefers inst.
    $display("[TB] sustained tie");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    data_if.wr = 1'b0; data_if.wstrb = 4'h0;
    inst_if.req = 1'b1; inst_if.addr = 32'h1000_0000;
    data_if.req = 1'b1; data_if.addr = 32'h2000_0000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_data = (k % 2) == 1;
`else
      exp_data = 1'b1;
`endif
      exp_addr = exp_data ? 32'h2000_0000 : 32'h1000_0000;
      @(negedge clk);
      sram_if.data_ok = 1'b0; sram_if.addr_ok = 1'b1;
      #1;
      check_output($sformatf("t3_k%0d_req", k),     sram_if.req,     1);
      check_output($sformatf("t3_k%0d_addr", k),    sram_if.addr,    exp_addr);
      check_output($sformatf("t3_k%0d_inst_ack", k), inst_if.addr_ok, !exp_data);
      check_output($sformatf("t3_k%0d_data_ack", k), data_if.addr_ok, exp_data);
      @(negedge clk);
      sram_if.addr_ok = 1'b0; sram_if.data_ok = 1'b1; sram_if.rdata = k;
      if (k == 3) begin
        inst_if.req = 1'b0; data_if.req = 1'b0;
      end
      #1;
      check_output($sformatf("t3_k%0d_data_req", k),  sram_if.req,     0);
      check_output($sformatf("t3_k%0d_inst_dok", k),  inst_if.data_ok, !exp_data);
      check_output($sformatf("t3_k%0d_data_dok", k),  data_if.data_ok, exp_data);
    end
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;
    #1 check_output("t3_end_req", sram_if.req, 0);

    // Slave stall: addr_ok held low for 10 cycles. A data request arriving
    // mid-stall must not steal the port.
    $display("[TB] slave stall");
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'hA000_0040; inst_if.wr = 1'b1;
    inst_if.wstrb = 4'h3; inst_if.wdata = 32'h0000_BEEF; inst_if.size = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        data_if.req = 1'b1; data_if.addr = 32'hA000_0080; data_if.wr = 1'b0;
      end
      #1;
      check_output($sformatf("t4_i%0d_req", i),   sram_if.req,     1);
      check_output($sformatf("t4_i%0d_addr", i),  sram_if.addr,    32'hA000_0040);
      check_output($sformatf("t4_i%0d_wr", i),    sram_if.wr,      1);
      check_output($sformatf("t4_i%0d_wstrb", i), sram_if.wstrb,   4'h3);
      check_output($sformatf("t4_i%0d_wdata", i), sram_if.wdata,   32'h0000_BEEF);
      check_output($sformatf("t4_i%0d_size", i),  sram_if.size,    2'd1);
      check_output($sformatf("t4_i%0d_iack", i),  inst_if.addr_ok, 0);
      check_output($sformatf("t4_i%0d_dack", i),  data_if.addr_ok, 0);
    end
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1 check_output("t4_inst_addr_ok", inst_if.addr_ok, 1);
    @(negedge clk);
    inst_if.req = 1'b0; sram_if.addr_ok = 1'b0; sram_if.data_ok = 1'b1;
    #1;
    check_output("t4_inst_data_ok", inst_if.data_ok, 1);
    check_output("t4_data_data_ok", data_if.data_ok, 0);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.addr_ok = 1'b1;
    #1;
    check_output("t4_next_req",     sram_if.req,     1);
    check_output("t4_next_addr",    sram_if.addr,    32'hA000_0080);
    check_output("t4_next_wr",      sram_if.wr,      0);
    check_output("t4_data_addr_ok", data_if.addr_ok, 1);
    @(negedge clk);
    data_if.req = 1'b0; sram_if.addr_ok = 1'b0;
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'hCAFE_F00D;
    #1;
    check_output("t4_data_rdata", data_if.rdata, 32'hCAFE_F00D);
    check_output("t4_inst_rdata", inst_if.rdata, 0);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;

    // Abort: data drops req in ADDR before addr_ok.
    $display("[TB] abort");
    @(negedge clk);
    data_if.req = 1'b1; data_if.addr = 32'h8000_2000;
    @(negedge clk); #1;
    check_output("t5_req_before", sram_if.req, 1);
    data_if.req = 1'b0;
    #1;
    check_output("t5_req_dropped", sram_if.req,     0);
    check_output("t5_no_addr_ok",  data_if.addr_ok, 0);
    @(negedge clk);
    data_if.req = 1'b1;
    #1;
    check_output("t5_idle_req",     sram_if.req,     0);
    check_output("t5_idle_data_ok", data_if.data_ok, 0);
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1;
    check_output("t5_regrant_req",  sram_if.req,     1);
    check_output("t5_data_addr_ok", data_if.addr_ok, 1);
    @(negedge clk);
    data_if.req = 1'b0; sram_if.addr_ok = 1'b0;
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h0000_55AA;
    #1 check_output("t5_data_rdata", data_if.rdata, 32'h0000_55AA);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;

    // Reset while waiting in DATA. The late response is then discarded.
    $display("[TB] reset mid-DATA");
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0100; inst_if.wr = 1'b0;
    inst_if.wstrb = 4'h0; inst_if.wdata = '0; inst_if.size = 2'd2;
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1 check_output("t6_addr_ok", inst_if.addr_ok, 1);
    @(negedge clk);
    inst_if.req = 1'b0; sram_if.addr_ok = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; sram_if.data_ok = 1'b1; sram_if.rdata = 32'hDEAD_DEAD;
    #1;
    check_output("t6_rst_req",     sram_if.req,     0);
    check_output("t6_rst_addr",    sram_if.addr,    0);
    check_output("t6_rst_addr_ok", inst_if.addr_ok, 0);
    check_output("t6_rst_data_ok", inst_if.data_ok, 0);
    check_output("t6_rst_rdata",   inst_if.rdata,   0);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0200;
    #1 check_output("t6_new_idle_req", sram_if.req, 0);
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1;
    check_output("t6_new_req",     sram_if.req,     1);
    check_output("t6_new_addr",    sram_if.addr,    32'hBFC0_0200);
    check_output("t6_new_addr_ok", inst_if.addr_ok, 1);
    @(negedge clk);
    inst_if.req = 1'b0; sram_if.addr_ok = 1'b0;
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h1111_2222;
    #1;
    check_output("t6_new_data_ok", inst_if.data_ok, 1);
    check_output("t6_new_rdata",   inst_if.rdata,   32'h1111_2222);
    @(negedge clk);
    sram_if.data_ok = 1'b0; sram_if.rdata = '0;
    #1 check_output("t6_end_req", sram_if.req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one sram-like slave port (toward the AXI bridge) between the instruction-fetch master (pre-IF/IF) and the data master (pre-MEM/MEM). At most one transaction is outstanding at a time. A registered grant FSM latches the owner, forwards its request fields, and routes `addr_ok`, `data_ok` and `rdata` back to that owner only.

## Interface
- `ADDR_W`, default 32: address width (virt_t).
- `DATA_W`, default 32: data width (uint32_t).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1 each  instruction-master request / write flag.
- `inst_size`  in  2  bytes = 1<<size; `inst_wstrb`  in  4  byte enables.
- `inst_addr`  in  ADDR_W; `inst_wdata`  in  DATA_W.
- `inst_addr_ok`, `inst_data_ok`  out  1 each  request accepted / response returned.
- `inst_rdata`  out  DATA_W  read data, valid with `inst_data_ok`.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`  in  same widths as inst  data-master request.
- `data_addr_ok`, `data_data_ok`  out  1 each; `data_rdata`  out  DATA_W.
- `req`, `wr`  out  1 each  to slave; `size`  out  2; `wstrb`  out  4; `addr`  out  ADDR_W; `wdata`  out  DATA_W.
- `addr_ok`, `data_ok`  in  1 each  from slave; `rdata`  in  DATA_W.

## Operation
- States: IDLE, ADDR, DATA. Register `owner` (0 = inst, 1 = data).
- IDLE: if any master `*_req` is high, pick a winner per Configuration, latch `owner`, go to ADDR. No slave `req` is driven in IDLE.
- ADDR: slave `req` = owner's `*_req`. `wr/size/wstrb/addr/wdata` are a combinational mux of the owner's fields. Owner's `*_addr_ok` = slave `addr_ok`.
  - On `req && addr_ok`, go to DATA.
  - If the owner drops `*_req` before acceptance, go to IDLE with no transaction.
- DATA: slave `req` = 0. Owner's `*_data_ok` = slave `data_ok`, and owner's `*_rdata` = slave `rdata`.
  - On `data_ok`, re-arbitrate in the same cycle. If any request is pending, latch the new owner and go to ADDR. Otherwise go to IDLE.
- The non-owner's `addr_ok` and `data_ok` are always 0. Its `rdata` is don't-care and driven as 0.
- Writes complete on slave `data_ok` exactly like reads; `rdata` is ignored for writes.
- Slave `data_ok` arriving in IDLE or ADDR is a protocol error. It is dropped and the assertion `arb_spurious_data_ok` fires.

## Timing
- Reset: state = IDLE, `owner` = 0, round-robin pointer = inst-preferred. `req` = 0, all master `*_addr_ok` and `*_data_ok` = 0, all data outputs = 0.
- Grant latency: 1 cycle from `*_req` rising in IDLE to slave `req`.
- Back-to-back throughput: the cycle after `data_ok` can present the next `req`. Minimum cycle count per transaction is 1 (grant) + 1 (ADDR) + slave latency.
- `addr_ok` pass-through to the owner is combinational, zero cycles. So is `data_ok`/`rdata` pass-through.
- Simultaneous requests in IDLE or at `data_ok`: exactly one winner per arbitration; the loser's `req` stays pending with no ack.
- Reset asserted in ADDR or DATA: return to IDLE next edge. An in-flight slave response after reset is discarded; it is not counted as an error for 1 transaction.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The pointer toggles to the other master after each grant.
  - On a tie, the master the pointer prefers wins.
  - A lone requester always wins regardless of the pointer.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, data over inst.
  - Data always wins ties, so inst can starve while data requests continuously.
  - The pointer register is not built.

## Test plan
- Single inst read: `inst_req=1`, `inst_addr=0xBFC00000`, slave `addr_ok` at cycle 2, `data_ok` with `rdata=0x3C080001` at cycle 4. Expect `inst_addr_ok` only at cycle 2, `inst_data_ok`/`inst_rdata=0x3C080001` at cycle 4, and all `data_*` acks 0.
- Tie, fixed priority: both request at cycle 0 with `data_wr=1`, `data_addr=0x80001000`, `data_wstrb=4'hF`. Expect slave `req` with `wr=1` and `addr=0x80001000` first. Expect inst granted the cycle after `data_ok`, and `addr=inst_addr`.
- Tie, `ARB_ROUND_ROBIN_EN`: both hold `req` for 4 transactions. Expect grant order inst, data, inst, data.
- Slave stall: `addr_ok` held 0 for 10 cycles. Expect `req` and all forwarded fields stable throughout, no master ack, and no owner change.
- Abort: owner drops `*_req` in ADDR before `addr_ok`. Expect IDLE next cycle, `req=0`, and no `data_ok` routed.
- Reset mid-DATA: `reset=1` for 1 cycle while waiting for `data_ok`. Expect all outputs 0 next cycle and state IDLE. A following single request completes normally.
